mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port SRAM between a fetch (read-only) port
// and a data (read/write) port. Grants are combinational and round-robin
// under contention. Read data returns one cycle after the grant and is
// steered to the port that issued the read.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   if_req_in, if_addr_in        fetch request / byte address
//   if_gnt_out                   fetch accepted this cycle
//   if_rvalid_out, if_rdata_out  fetch read response
//   d_req_in, d_we_in, d_be_in,  data request, write flag, byte enables,
//   d_addr_in, d_wdata_in        byte address, write data
//   d_gnt_out                    data accepted this cycle
//   d_rvalid_out, d_rdata_out    data read response (reads only)
//   mem_en_out, mem_we_out,      SRAM enable, byte write enables,
//   mem_addr_out, mem_wdata_out  address, write data
//   mem_rdata_in                 SRAM read data, one cycle after a read
//   if_stall_cnt_out,            saturating counts of cycles spent
//   d_stall_cnt_out              requesting without a grant
//
// Route state (who owns the SRAM read data in the next cycle)
//   state       | meaning
//   ROUTE_NONE  | no read outstanding, both rvalid low
//   ROUTE_IF    | fetch read issued last cycle, if_rvalid high
//   ROUTE_D     | data read issued last cycle, d_rvalid high

module mem_arbiter #(
   parameter int ADDR_WIDTH      = 12,
   parameter int DATA_WIDTH      = 32,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         if_req_in,
   input  logic [ADDR_WIDTH-1:0]        if_addr_in,
   output logic                         if_gnt_out,
   output logic                         if_rvalid_out,
   output logic [DATA_WIDTH-1:0]        if_rdata_out,
   input  logic                         d_req_in,
   input  logic                         d_we_in,
   input  logic [DATA_WIDTH/8-1:0]      d_be_in,
   input  logic [ADDR_WIDTH-1:0]        d_addr_in,
   input  logic [DATA_WIDTH-1:0]        d_wdata_in,
   output logic                         d_gnt_out,
   output logic                         d_rvalid_out,
   output logic [DATA_WIDTH-1:0]        d_rdata_out,
   output logic                         mem_en_out,
   output logic [DATA_WIDTH/8-1:0]      mem_we_out,
   output logic [ADDR_WIDTH-1:0]        mem_addr_out,
   output logic [DATA_WIDTH-1:0]        mem_wdata_out,
   input  logic [DATA_WIDTH-1:0]        mem_rdata_in,
   output logic [STALL_CNT_WIDTH-1:0]   if_stall_cnt_out,
   output logic [STALL_CNT_WIDTH-1:0]   d_stall_cnt_out
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;

   localparam logic [1:0] ROUTE_NONE = 2'd0;
   localparam logic [1:0] ROUTE_IF   = 2'd1;
   localparam logic [1:0] ROUTE_D    = 2'd2;

   localparam logic WIN_IF = 1'b0;
   localparam logic WIN_D  = 1'b1;

   logic                       last_winner_q, last_winner_d;
   logic [1:0]                 route_q, route_d;
   logic [STALL_CNT_WIDTH-1:0] if_stall_q, if_stall_d;
   logic [STALL_CNT_WIDTH-1:0] d_stall_q, d_stall_d;
   logic                       if_gnt, d_gnt;

   // Requests seen while rst is high are never granted.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!rst) begin
         if (if_req_in && d_req_in) begin
            if (last_winner_q == WIN_D) if_gnt = 1'b1;
            else                        d_gnt  = 1'b1;
         end else if (if_req_in) begin
            if_gnt = 1'b1;
         end else if (d_req_in) begin
            d_gnt = 1'b1;
         end
      end
   end

   assign if_gnt_out    = if_gnt;
   assign d_gnt_out     = d_gnt;
   assign mem_en_out    = if_gnt | d_gnt;
   assign mem_addr_out  = d_gnt ? d_addr_in : if_addr_in;
   assign mem_we_out    = (d_gnt && d_we_in) ? d_be_in : {BE_WIDTH{1'b0}};
   assign mem_wdata_out = d_wdata_in;

   always_comb begin
      last_winner_d = last_winner_q;
      if (if_gnt)     last_winner_d = WIN_IF;
      else if (d_gnt) last_winner_d = WIN_D;

      route_d = ROUTE_NONE;
      if (if_gnt)                 route_d = ROUTE_IF;
      else if (d_gnt && !d_we_in) route_d = ROUTE_D;

      if_stall_d = if_stall_q;
      if (if_req_in && !if_gnt && (if_stall_q != {STALL_CNT_WIDTH{1'b1}}))
         if_stall_d = if_stall_q + 1'b1;

      d_stall_d = d_stall_q;
      if (d_req_in && !d_gnt && (d_stall_q != {STALL_CNT_WIDTH{1'b1}}))
         d_stall_d = d_stall_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_winner_q <= WIN_D;
         route_q       <= ROUTE_NONE;
         if_stall_q    <= '0;
         d_stall_q     <= '0;
      end else begin
         last_winner_q <= last_winner_d;
         route_q       <= route_d;
         if_stall_q    <= if_stall_d;
         d_stall_q     <= d_stall_d;
      end
   end

   // Gating with rst drops a response whose grant was followed by reset.
   assign if_rvalid_out = !rst && (route_q == ROUTE_IF);
   assign d_rvalid_out  = !rst && (route_q == ROUTE_D);
   assign if_rdata_out  = if_rvalid_out ? mem_rdata_in : {DATA_WIDTH{1'b0}};
   assign d_rdata_out   = d_rvalid_out  ? mem_rdata_in : {DATA_WIDTH{1'b0}};

   assign if_stall_cnt_out = if_stall_q;
   assign d_stall_cnt_out  = d_stall_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int SW = 10;
   localparam int BW = DW / 8;
   localparam logic [SW-1:0] SAT = {SW{1'b1}};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [BW-1:0] d_be = '0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          mem_en;
   logic [BW-1:0] mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [SW-1:0] if_stall, d_stall;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STALL_CNT_WIDTH(SW)) dut (
      .clk(clk), .rst(rst),
      .if_req_in(if_req), .if_addr_in(if_addr), .if_gnt_out(if_gnt),
      .if_rvalid_out(if_rvalid), .if_rdata_out(if_rdata),
      .d_req_in(d_req), .d_we_in(d_we), .d_be_in(d_be), .d_addr_in(d_addr),
      .d_wdata_in(d_wdata), .d_gnt_out(d_gnt), .d_rvalid_out(d_rvalid),
      .d_rdata_out(d_rdata),
      .mem_en_out(mem_en), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
      .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata),
      .if_stall_cnt_out(if_stall), .d_stall_cnt_out(d_stall)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      if_addr = 12'h100; d_addr = 12'h200;
      tick(); tick(); settle();
      n_checks++; if (if_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_if_gnt: got %b expected 0", if_gnt); end
      n_checks++; if (d_gnt !== 1'b0) begin n_errors++; $display("FAIL rst_d_gnt: got %b expected 0", d_gnt); end
      n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL rst_mem_en: got %b expected 0", mem_en); end
      n_checks++; if (mem_we !== 4'b0000) begin n_errors++; $display("FAIL rst_mem_we: got %b expected 0000", mem_we); end
      n_checks++; if ({if_rvalid, d_rvalid} !== 2'b00) begin n_errors++; $display("FAIL rst_rvalid: got %b expected 00", {if_rvalid, d_rvalid}); end
      n_checks++; if (if_stall !== '0) begin n_errors++; $display("FAIL rst_if_stall: got %0d expected 0", if_stall); end
      n_checks++; if (d_stall !== '0) begin n_errors++; $display("FAIL rst_d_stall: got %0d expected 0", d_stall); end
   endtask

   // Both ports read from the first cycle after reset: IF, D, IF, D, ...
   task automatic test_contention();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i == 6) begin if_req = 1'b0; d_req = 1'b0; end
         mem_rdata = 32'hC0DE_0000 + i;
         settle();
         if (i > 0) begin
            n_checks++; if (if_rvalid !== ((i - 1) % 2 == 0)) begin n_errors++; $display("FAIL rr_if_rvalid[%0d]: got %b expected %b", i, if_rvalid, ((i - 1) % 2 == 0)); end
            n_checks++; if (d_rvalid !== ((i - 1) % 2 == 1)) begin n_errors++; $display("FAIL rr_d_rvalid[%0d]: got %b expected %b", i, d_rvalid, ((i - 1) % 2 == 1)); end
            if ((i - 1) % 2 == 0) begin
               n_checks++; if (if_rdata !== 32'hC0DE_0000 + i) begin n_errors++; $display("FAIL rr_if_rdata[%0d]: got %h expected %h", i, if_rdata, 32'hC0DE_0000 + i); end
               n_checks++; if (d_rdata !== 32'h0) begin n_errors++; $display("FAIL rr_d_rdata_zero[%0d]: got %h expected 0", i, d_rdata); end
            end else begin
               n_checks++; if (d_rdata !== 32'hC0DE_0000 + i) begin n_errors++; $display("FAIL rr_d_rdata[%0d]: got %h expected %h", i, d_rdata, 32'hC0DE_0000 + i); end
               n_checks++; if (if_rdata !== 32'h0) begin n_errors++; $display("FAIL rr_if_rdata_zero[%0d]: got %h expected 0", i, if_rdata); end
            end
         end
         if (i < 6) begin
            n_checks++; if ({if_gnt, d_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {if_gnt, d_gnt}, ((i % 2 == 0) ? 2'b10 : 2'b01)); end
            n_checks++; if (mem_addr !== ((i % 2 == 0) ? 12'h100 : 12'h200)) begin n_errors++; $display("FAIL rr_mem_addr[%0d]: got %h expected %h", i, mem_addr, ((i % 2 == 0) ? 12'h100 : 12'h200)); end
         end else begin
            n_checks++; if (mem_en !== 1'b0) begin n_errors++; $display("FAIL rr_idle_en: got %b expected 0", mem_en); end
         end
         tick();
      end
      n_checks++; if (if_stall !== 10'd3) begin n_errors++; $display("FAIL rr_if_stall: got %0d expected 3", if_stall); end
      n_checks++; if (d_stall !== 10'd3) begin n_errors++; $display("FAIL rr_d_stall: got %0d expected 3", d_stall); end
   endtask

   task automatic test_fetch_stream();
      for (int i = 0; i < 4; i++) begin
         if_req = (i < 3);
         if_addr = 12'(i * 4);
         mem_rdata = 32'h1111_0000 + i;
         settle();
         if (i < 3) begin
            n_checks++; if ({mem_en, if_gnt, d_gnt} !== 3'b110) begin n_errors++; $display("FAIL fs_gnt[%0d]: got %b expected 110", i, {mem_en, if_gnt, d_gnt}); end
            n_checks++; if (mem_addr !== 12'(i * 4)) begin n_errors++; $display("FAIL fs_addr[%0d]: got %h expected %h", i, mem_addr, 12'(i * 4)); end
         end
         if (i == 0) begin
            n_checks++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h0}) begin n_errors++; $display("FAIL fs_idle_rdata: got %b/%h expected 0/0", if_rvalid, if_rdata); end
         end else begin
            n_checks++; if (if_rvalid !== 1'b1) begin n_errors++; $display("FAIL fs_rvalid[%0d]: got %b expected 1", i, if_rvalid); end
            n_checks++; if (if_rdata !== 32'h1111_0000 + i) begin n_errors++; $display("FAIL fs_rdata[%0d]: got %h expected %h", i, if_rdata, 32'h1111_0000 + i); end
         end
         tick();
      end
      settle();
      n_checks++; if (if_rvalid !== 1'b0) begin n_errors++; $display("FAIL fs_rvalid_end: got %b expected 0", if_rvalid); end
   endtask

   task automatic test_write();
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 12'h010; d_wdata = 32'hDEAD_BEEF;
      settle();
      n_checks++; if ({d_gnt, if_gnt, mem_en} !== 3'b101) begin n_errors++; $display("FAIL wr_gnt: got %b expected 101", {d_gnt, if_gnt, mem_en}); end
      n_checks++; if (mem_we !== 4'b0011) begin n_errors++; $display("FAIL wr_mem_we: got %b expected 0011", mem_we); end
      n_checks++; if (mem_addr !== 12'h010) begin n_errors++; $display("FAIL wr_mem_addr: got %h expected 010", mem_addr); end
      n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL wr_mem_wdata: got %h expected deadbeef", mem_wdata); end
      tick();
      d_req = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      settle();
      n_checks++; if ({d_rvalid, d_rdata} !== {1'b0, 32'h0}) begin n_errors++; $display("FAIL wr_no_rvalid: got %b/%h expected 0/0", d_rvalid, d_rdata); end
      d_req = 1'b1; d_we = 1'b0;
      settle();
      n_checks++; if ({d_gnt, mem_en, mem_we} !== {2'b11, 4'b0000}) begin n_errors++; $display("FAIL rd_gnt: got %b expected 110000", {d_gnt, mem_en, mem_we}); end
      tick();
      d_req = 1'b0; mem_rdata = 32'h0000_BEEF;
      settle();
      n_checks++; if ({d_rvalid, d_rdata} !== {1'b1, 32'h0000_BEEF}) begin n_errors++; $display("FAIL rd_rdata: got %b/%h expected 1/0000beef", d_rvalid, d_rdata); end
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0000;
      settle();
      n_checks++; if ({d_gnt, mem_en, mem_we} !== {2'b11, 4'b0000}) begin n_errors++; $display("FAIL wr_be0: got %b expected 110000", {d_gnt, mem_en, mem_we}); end
      tick();
      d_req = 1'b0; d_we = 1'b0;
      settle();
      n_checks++; if (d_rvalid !== 1'b0) begin n_errors++; $display("FAIL wr_be0_rvalid: got %b expected 0", d_rvalid); end
   endtask

   task automatic test_stall();
      rst = 1'b1;
      tick();
      rst = 1'b0; if_req = 1'b1; d_req = 1'b1; if_addr = 12'h040; d_addr = 12'h080;
      for (int i = 0; i < 5; i++) begin
         settle();
         n_checks++; if (d_gnt !== (i % 2 == 1)) begin n_errors++; $display("FAIL st_d_gnt[%0d]: got %b expected %b", i, d_gnt, (i % 2 == 1)); end
         tick();
         n_checks++; if (d_stall !== SW'(i / 2 + 1)) begin n_errors++; $display("FAIL st_d_cnt[%0d]: got %0d expected %0d", i, d_stall, i / 2 + 1); end
      end
      n_checks++; if (if_stall !== 10'd2) begin n_errors++; $display("FAIL st_if_cnt: got %0d expected 2", if_stall); end
      // Withdrawn requests leave the counters untouched.
      if_req = 1'b0; d_req = 1'b0;
      tick();
      n_checks++; if ({if_stall, d_stall} !== {10'd2, 10'd3}) begin n_errors++; $display("FAIL st_hold: got %0d/%0d expected 2/3", if_stall, d_stall); end
      if_req = 1'b1; d_req = 1'b1;
      for (int i = 0; i < 2100; i++) tick();
      n_checks++; if (if_stall !== SAT) begin n_errors++; $display("FAIL st_if_sat: got %h expected %h", if_stall, SAT); end
      n_checks++; if (d_stall !== SAT) begin n_errors++; $display("FAIL st_d_sat: got %h expected %h", d_stall, SAT); end
      if_req = 1'b0; d_req = 1'b0;
      tick();
      n_checks++; if ({if_stall, d_stall} !== {SAT, SAT}) begin n_errors++; $display("FAIL st_sat_hold: got %h/%h expected %h/%h", if_stall, d_stall, SAT, SAT); end
   endtask

   task automatic test_rst_after_grant();
      if_req = 1'b1; d_req = 1'b0; if_addr = 12'h020;
      settle();
      n_checks++; if (if_gnt !== 1'b1) begin n_errors++; $display("FAIL rg_gnt: got %b expected 1", if_gnt); end
      tick();
      if_req = 1'b0; rst = 1'b1; mem_rdata = 32'h5555_AAAA;
      settle();
      n_checks++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h0}) begin n_errors++; $display("FAIL rg_rvalid: got %b/%h expected 0/0", if_rvalid, if_rdata); end
      tick();
      rst = 1'b0;
      settle();
      n_checks++; if ({if_stall, d_stall} !== {10'd0, 10'd0}) begin n_errors++; $display("FAIL rg_cnt: got %0d/%0d expected 0/0", if_stall, d_stall); end
      n_checks++; if (if_rvalid !== 1'b0) begin n_errors++; $display("FAIL rg_rvalid_after: got %b expected 0", if_rvalid); end
      if_req = 1'b1; d_req = 1'b1;
      settle();
      n_checks++; if ({if_gnt, d_gnt} !== 2'b10) begin n_errors++; $display("FAIL rg_next_gnt: got %b expected 10", {if_gnt, d_gnt}); end
      tick();
      if_req = 1'b0; d_req = 1'b0; mem_rdata = 32'h1234_5678;
      settle();
      n_checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h1234_5678}) begin n_errors++; $display("FAIL rg_resume: got %b/%h expected 1/12345678", if_rvalid, if_rdata); end
      tick();
   endtask

   initial begin
      test_reset();
      test_contention();
      test_fetch_stream();
      test_write();
      test_stall();
      test_rst_after_grant();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
